seq_det_arbiter: RTL and testbench
==================================

// Module: seq_det_arbiter
// PURPOSE
//  Shares one serial pattern detector between NREQ serial bit sources. Grants the
//  detector round-robin, one fixed-length frame per grant. Scans the granted stream
//  for a programmable PAT_W-bit pattern (overlapping matches) and reports per-bit
//  match pulses plus a per-frame hit summary. Sits between the serial sources and
//  downstream status/count logic.
// PARAMETERS
//  NREQ      4        number of requesters (>=2)
//  FRAME_LEN 8        bits per granted frame (>=PAT_W)
//  PAT_W     4        pattern width in bits
//  PAT_RST   4'b1011  pattern value after reset
//  CNT_W     4        width of frame_hits (saturating)
// PORTS
//  clk         in   1              rising-edge clock
//  reset       in   1              synchronous, active-low reset
//  req         in   NREQ           per-source frame request, level
//  bit_in      in   NREQ           per-source serial data
//  pat_wr      in   1              pattern write strobe
//  pat_in      in   PAT_W          new pattern
//  grant       out  NREQ           one-hot grant, registered
//  busy        out  1              state != IDLE
//  match       out  1              1-cycle pulse: last PAT_W frame bits == pattern
//  frame_done  out  1              1-cycle pulse in DONE
//  frame_id    out  $clog2(NREQ)   index of source just served (valid with frame_done)
//  frame_hits  out  CNT_W          matches in that frame (valid with frame_done)
//  aborted     out  1              frame ended early (valid with frame_done)
//  cfg_err     out  1              1-cycle pulse: pat_wr rejected
// BEHAVIOUR
//  - Reset (reset==0 at edge): state IDLE, all outputs 0, pattern=PAT_RST, rr pointer=NREQ-1.
//  - FSM: IDLE -> STREAM -> DONE -> IDLE.
//  - IDLE: if req!=0, pick first set req searching from pointer+1 (wrapping).
//    Next cycle: STREAM, grant one-hot, pointer=winner. With req==0, stay IDLE.
//  - STREAM: bit_in[winner] is sampled on each edge while grant is high, for FRAME_LEN
//    edges. Shift reg and bit count are cleared at frame start; no match spans frames.
//  - match: asserted the cycle after the sampled bit that completes the pattern,
//    only once bit count >= PAT_W. Overlap is allowed (1011011 -> 2 hits).
//  - frame_hits saturates at 2^CNT_W-1.
//  - After the FRAME_LEN-th sample: DONE for exactly 1 cycle. grant=0, frame_done=1,
//    frame_id/frame_hits/aborted are valid. Next cycle: IDLE.
//    Minimum gap between frames is 2 cycles (DONE, IDLE).
//  - Abort: req[winner] low at an edge in STREAM -> that bit is not sampled.
//    Go to DONE with aborted=1 and partial hits. Pointer still advances.
//  - pat_wr: accepted only in IDLE; pattern updates at that edge.
//    In STREAM/DONE: ignored, cfg_err pulses next cycle, pattern unchanged.
//  - req changes by non-granted sources mid-frame: no effect until the next IDLE.
//  - Reset mid-frame: reset values apply at the next edge; partial frame is discarded
//    with no frame_done.
// STRUCTURE
//  - Shared header seq_det_defs.vh: state encodings (IDLE=2'd0, STREAM=2'd1,
//    DONE=2'd2), PAT_RST default.
//  - Sub-module rr_arbiter: req + pointer -> one-hot winner + index (combinational
//    search; registered by parent).
//  - Parent holds FSM, shift reg, bit counter, hit counter, pattern register.
// TESTING (NREQ=4, FRAME_LEN=8, PAT_W=4, pattern 1011 unless stated)
//  1 Reset: reset=0 for 2 cycles -> grant=0000, busy=0, match=0, cfg_err=0,
//    pattern=1011.
//  2 req=0100, bits 1,0,1,1,0,1,1,0 -> grant=0100 one cycle after req.
//    match pulses after bits 4 and 7. frame_done with frame_id=2, frame_hits=2,
//    aborted=0.
//  3 req=1111 held -> grants 0001,0010,0100,1000,0001 in order, each 8 cycles high.
//    1 DONE + 1 IDLE cycle between grants.
//  4 pat_wr=1, pat_in=1110 in IDLE; then frame 1,1,1,0,1,1,1,0 -> frame_hits=2.
//    pat_wr during STREAM -> cfg_err=1, pattern stays 1110.
//  5 Single requester drops req at bit 3 of a frame -> DONE next edge, aborted=1,
//    frame_hits=0. Next winner is searched from the following index.
//  6 reset=0 at bit 5 of a frame for source 2, with req=1111 -> grant=0000,
//    no frame_done, pattern=1011. First grant after release is 0001.

Source files
------------

// File: rtl/seq_det_arbiter_pkg.sv
// Shared types for the round-robin serial pattern detector: FSM state encoding,
// default pattern and the ring-index helper used by the arbiter search.
package seq_det_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [3:0] PAT_RST_DEFAULT = 4'b1011;

  // Position 'off' steps after 'base' on a ring of n requesters.
  function automatic int rr_index(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/seq_det_arbiter_rr_arbiter.sv
// Combinational round-robin search: first set request strictly after the pointer,
// wrapping, returned as one-hot plus index. The parent registers the result.
module rr_arbiter
  import seq_det_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    // Offset NREQ lands back on the pointer itself, so it is the last choice.
    for (int k = 1; k <= NREQ; k++) begin
      if (!valid && req[rr_index(int'(ptr), k, NREQ)]) begin
        valid = 1'b1;
        idx   = IDX_W'(rr_index(int'(ptr), k, NREQ));
        gnt[rr_index(int'(ptr), k, NREQ)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_det_arbiter.sv
// One serial pattern detector shared round-robin between NREQ bit sources, one
// fixed-length frame per grant, with per-bit match pulses and a per-frame summary.
module seq_det_arbiter
  import seq_det_arbiter_pkg::*;
#(
  parameter int               NREQ      = 4,
  parameter int               FRAME_LEN = 8,
  parameter int               PAT_W     = 4,
  parameter logic [PAT_W-1:0] PAT_RST   = PAT_W'(PAT_RST_DEFAULT),
  parameter int               CNT_W     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          bit_in,
  input  logic                     pat_wr,
  input  logic [PAT_W-1:0]         pat_in,
  output logic [NREQ-1:0]          grant,
  output logic                     busy,
  output logic                     match,
  output logic                     frame_done,
  output logic [$clog2(NREQ)-1:0]  frame_id,
  output logic [CNT_W-1:0]         frame_hits,
  output logic                     aborted,
  output logic                     cfg_err
);

  localparam int IDX_W  = $clog2(NREQ);
  localparam int BCNT_W = $clog2(FRAME_LEN + 1);

  state_e             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [PAT_W-1:0]   r_pat;
  logic [PAT_W-1:0]   r_shift;
  logic [BCNT_W-1:0]  r_bcnt;
  logic [CNT_W-1:0]   r_hits;
  logic [NREQ-1:0]    r_grant;
  logic               r_match;
  logic               r_frame_done;
  logic [IDX_W-1:0]   r_frame_id;
  logic [CNT_W-1:0]   r_frame_hits;
  logic               r_aborted;
  logic               r_cfg_err;

  logic [NREQ-1:0]    w_arb_gnt;
  logic [IDX_W-1:0]   w_arb_idx;
  logic               w_arb_valid;
  logic               w_bit;
  logic               w_req_live;
  logic [PAT_W-1:0]   w_shift_next;
  logic [BCNT_W-1:0]  w_bcnt_next;
  logic               w_hit;
  logic [CNT_W-1:0]   w_hits_next;
  logic               w_last_bit;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (req),
    .ptr   (r_ptr),
    .gnt   (w_arb_gnt),
    .idx   (w_arb_idx),
    .valid (w_arb_valid)
  );

  assign w_bit        = bit_in[r_ptr];
  assign w_req_live   = req[r_ptr];
  assign w_shift_next = {r_shift[PAT_W-2:0], w_bit};
  assign w_bcnt_next  = r_bcnt + 1'b1;
  // Shift register is cleared per frame, so the count guard stops zero-fill false hits.
  assign w_hit        = (w_bcnt_next >= BCNT_W'(PAT_W)) && (w_shift_next == r_pat);
  assign w_hits_next  = (w_hit && (r_hits != {CNT_W{1'b1}})) ? r_hits + 1'b1 : r_hits;
  assign w_last_bit   = (w_bcnt_next == BCNT_W'(FRAME_LEN));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_ptr        <= IDX_W'(NREQ - 1);
      r_pat        <= PAT_RST;
      r_shift      <= '0;
      r_bcnt       <= '0;
      r_hits       <= '0;
      r_grant      <= '0;
      r_match      <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_id   <= '0;
      r_frame_hits <= '0;
      r_aborted    <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_match      <= 1'b0;
      r_frame_done <= 1'b0;
      r_cfg_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (pat_wr) r_pat <= pat_in;
          if (w_arb_valid) begin
            r_state <= ST_STREAM;
            r_grant <= w_arb_gnt;
            r_ptr   <= w_arb_idx;
            r_shift <= '0;
            r_bcnt  <= '0;
            r_hits  <= '0;
          end
        end
        ST_STREAM: begin
          if (pat_wr) r_cfg_err <= 1'b1;
          if (!w_req_live) begin
            r_state      <= ST_DONE;
            r_grant      <= '0;
            r_frame_done <= 1'b1;
            r_frame_id   <= r_ptr;
            r_frame_hits <= r_hits;
            r_aborted    <= 1'b1;
          end else begin
            r_shift <= w_shift_next;
            r_bcnt  <= w_bcnt_next;
            r_hits  <= w_hits_next;
            r_match <= w_hit;
            if (w_last_bit) begin
              r_state      <= ST_DONE;
              r_grant      <= '0;
              r_frame_done <= 1'b1;
              r_frame_id   <= r_ptr;
              r_frame_hits <= w_hits_next;
              r_aborted    <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          if (pat_wr) r_cfg_err <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant      = r_grant;
  assign busy       = (r_state != ST_IDLE);
  assign match      = r_match;
  assign frame_done = r_frame_done;
  assign frame_id   = r_frame_id;
  assign frame_hits = r_frame_hits;
  assign aborted    = r_aborted;
  assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Directed bench for seq_det_arbiter: a vector table for reset and a single frame,
// then hand-written sequences for rotation, pattern writes, abort and mid-frame reset.
module tb_seq_det_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] bit_in = '0;
  logic       pat_wr = 1'b0;
  logic [3:0] pat_in = '0;
  logic [3:0] grant;
  logic       busy, match, frame_done, aborted, cfg_err;
  logic [1:0] frame_id;
  logic [3:0] frame_hits;

  int total = 0;
  int bad   = 0;

  seq_det_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .bit_in     (bit_in),
    .pat_wr     (pat_wr),
    .pat_in     (pat_in),
    .grant      (grant),
    .busy       (busy),
    .match      (match),
    .frame_done (frame_done),
    .frame_id   (frame_id),
    .frame_hits (frame_hits),
    .aborted    (aborted),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] bits;
    logic [3:0] grant;
    logic       busy;
    logic       match;
    logic       fd;
    logic [1:0] fid;
    logic [3:0] hits;
    logic       ab;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    logic [7:0] fbits;

    // reset x2, then source 2 streams 1,0,1,1,0,1,1,0
    vecs[0]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0};
    vecs[1]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0};
    vecs[2]  = '{1'b1, 4'h4, 4'h0, 4'h4, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0};
    vecs[3]  = '{1'b1, 4'h4, 4'h4, 4'h4, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0};
    vecs[4]  = '{1'b1, 4'h4, 4'h0, 4'h4, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0};
    vecs[5]  = '{1'b1, 4'h4, 4'h4, 4'h4, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0};
    vecs[6]  = '{1'b1, 4'h4, 4'h4, 4'h4, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0};
    vecs[7]  = '{1'b1, 4'h4, 4'h0, 4'h4, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0};
    vecs[8]  = '{1'b1, 4'h4, 4'h4, 4'h4, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0};
    vecs[9]  = '{1'b1, 4'h4, 4'h4, 4'h4, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0};
    vecs[10] = '{1'b1, 4'h4, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 2'd2, 4'd2, 1'b0};
    vecs[11] = '{1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      reset  = vecs[i].rst_n;
      req    = vecs[i].req;
      bit_in = vecs[i].bits;
      step();
      check($sformatf("vec%0d grant", i), 32'(grant), 32'(vecs[i].grant));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d match", i), 32'(match), 32'(vecs[i].match));
      check($sformatf("vec%0d frame_done", i), 32'(frame_done), 32'(vecs[i].fd));
      check($sformatf("vec%0d cfg_err", i), 32'(cfg_err), 32'd0);
      if (vecs[i].fd) begin
        check($sformatf("vec%0d frame_id", i), 32'(frame_id), 32'(vecs[i].fid));
        check($sformatf("vec%0d frame_hits", i), 32'(frame_hits), 32'(vecs[i].hits));
        check($sformatf("vec%0d aborted", i), 32'(aborted), 32'(vecs[i].ab));
      end
      $display("vec %0d: grant=%b busy=%b match=%b fd=%b", i, grant, busy, match, frame_done);
    end

    // Rotation with all sources requesting, starting from a fresh pointer.
    reset = 1'b0; step(); reset = 1'b1;
    req = 4'hF; bit_in = 4'h0;
    for (int f = 0; f < 5; f++) begin
      for (int c = 0; c < 8; c++) begin
        step();
        check($sformatf("rr f%0d c%0d grant", f, c), 32'(grant), 32'(4'b0001 << (f % 4)));
      end
      step();
      check($sformatf("rr f%0d done grant", f), 32'(grant), 32'd0);
      check($sformatf("rr f%0d frame_done", f), 32'(frame_done), 32'd1);
      check($sformatf("rr f%0d frame_id", f), 32'(frame_id), 32'(f % 4));
      check($sformatf("rr f%0d hits", f), 32'(frame_hits), 32'd0);
      step();
      check($sformatf("rr f%0d idle busy", f), 32'(busy), 32'd0);
      check($sformatf("rr f%0d idle grant", f), 32'(grant), 32'd0);
      $display("rr frame %0d: id=%0d", f, frame_id);
    end
    req = 4'h0;

    // Pattern write in IDLE, then a rejected write mid-frame.
    pat_wr = 1'b1; pat_in = 4'b1110;
    step();
    check("patwr idle cfg_err", 32'(cfg_err), 32'd0);
    pat_wr = 1'b0; req = 4'b0001;
    step();
    check("pat frame grant", 32'(grant), 32'h1);
    fbits = 8'b1110_1110;
    for (int i = 0; i < 8; i++) begin
      bit_in = {3'b000, fbits[7-i]};
      pat_wr = (i == 1);
      pat_in = 4'b0000;
      step();
      check($sformatf("pat bit%0d match", i), 32'(match), 32'((i == 3) || (i == 7)));
      check($sformatf("pat bit%0d cfg_err", i), 32'(cfg_err), 32'(i == 1));
    end
    pat_wr = 1'b0;
    check("pat frame_done", 32'(frame_done), 32'd1);
    check("pat frame_hits", 32'(frame_hits), 32'd2);
    check("pat frame_id", 32'(frame_id), 32'd0);
    check("pat aborted", 32'(aborted), 32'd0);
    $display("pattern frame: hits=%0d", frame_hits);
    req = 4'h0; bit_in = 4'h0;
    step();

    // Abort: source 1 drops req before its fourth bit.
    req = 4'b0010;
    step();
    check("abort grant", 32'(grant), 32'h2);
    for (int i = 0; i < 3; i++) step();
    req = 4'b0000;
    step();
    check("abort frame_done", 32'(frame_done), 32'd1);
    check("abort aborted", 32'(aborted), 32'd1);
    check("abort hits", 32'(frame_hits), 32'd0);
    check("abort frame_id", 32'(frame_id), 32'd1);
    check("abort grant low", 32'(grant), 32'd0);
    $display("abort frame: id=%0d aborted=%b", frame_id, aborted);
    step();
    req = 4'b0011;
    step();
    check("post-abort winner", 32'(grant), 32'h1);
    req = 4'b0000;
    step(); step();

    // Mid-frame reset during a frame for source 2.
    req = 4'b0100;
    step();
    check("rst frame grant", 32'(grant), 32'h4);
    req = 4'hF;
    for (int i = 0; i < 4; i++) step();
    reset = 1'b0;
    step();
    check("rst grant", 32'(grant), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst frame_done", 32'(frame_done), 32'd0);
    step();
    check("rst2 frame_done", 32'(frame_done), 32'd0);
    reset = 1'b1;
    step();
    check("post-rst grant", 32'(grant), 32'h1);
    fbits = 8'b1011_0000;
    for (int i = 0; i < 4; i++) begin
      bit_in = {3'b000, fbits[7-i]};
      step();
      check($sformatf("post-rst bit%0d match", i), 32'(match), 32'(i == 3));
    end
    $display("post-reset frame: grant=%b", grant);
    req = 4'h0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
